free_list_ckpt: RTL

Parametrised speculative physical-register free list with an internal checkpoint table for the rename stage. It hands out up to DISPATCH_W free physical tags per cycle and accepts up to COMMIT_W released tags per cycle, both packed into a circular buffer. It snapshots the head pointer for up to NUM_CKPT in-flight branches and restores any snapshot in a single cycle on misprediction. It sits between dispatch/rename and retire, beside the speculative rename map.

---
 rtl/free_list_ckpt.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/free_list_ckpt.sv
// Speculative physical-register free list for rename: circular tag buffer with
// compacted multi-lane allocate/release and a small head-pointer checkpoint queue.
module free_list_ckpt #(
    parameter int unsigned DEPTH      = 96,
    parameter int unsigned PHYS_LOG   = 7,
    parameter int unsigned PHYS_BASE  = 32,
    parameter int unsigned DISPATCH_W = 4,
    parameter int unsigned COMMIT_W   = 4,
    parameter int unsigned NUM_CKPT   = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           stall_i,
    input  logic [DISPATCH_W-1:0]          alloc_req_i,
    output logic                           alloc_grant_o,
    output logic [DISPATCH_W*PHYS_LOG-1:0] alloc_reg_o,
    input  logic [COMMIT_W-1:0]            free_valid_i,
    input  logic [COMMIT_W*PHYS_LOG-1:0]   free_reg_i,
    input  logic                           ckpt_take_i,
    output logic [$clog2(NUM_CKPT)-1:0]    ckpt_id_o,
    output logic                           ckpt_full_o,
    input  logic                           ckpt_restore_i,
    input  logic [$clog2(NUM_CKPT)-1:0]    ckpt_restore_id_i,
    input  logic                           ckpt_release_i,
    input  logic                           flush_i,
    output logic [$clog2(DEPTH):0]         count_o,
    output logic                           empty_o
);

    localparam int unsigned IW = $clog2(DEPTH);
    localparam int unsigned CW = IW + 1;
    localparam int unsigned KW = $clog2(NUM_CKPT);

    // {wrap, index}
    typedef logic [IW:0] ptr_t;

    function automatic ptr_t ptr_adv(input ptr_t p, input logic [CW-1:0] n);
        logic [CW:0] sum;
        ptr_t        q;
        sum = {2'b00, p[IW-1:0]} + {1'b0, n};
        if (sum >= (CW+1)'(DEPTH)) begin
            q = {~p[IW], IW'(sum - (CW+1)'(DEPTH))};
        end else begin
            q = {p[IW], IW'(sum)};
        end
        return q;
    endfunction

    function automatic logic [CW-1:0] ptr_count(input ptr_t h, input ptr_t t);
        if (h[IW] == t[IW]) begin
            return {1'b0, t[IW-1:0]} - {1'b0, h[IW-1:0]};
        end
        return CW'(DEPTH) - {1'b0, h[IW-1:0]} + {1'b0, t[IW-1:0]};
    endfunction

    logic [PHYS_LOG-1:0] r_mem [DEPTH];
    ptr_t                r_head;
    ptr_t                r_tail;
    ptr_t                r_slot [NUM_CKPT];
    logic [KW-1:0]       r_oldest;
    logic [KW:0]         r_live;

    logic [CW-1:0]       w_n;
    logic [CW-1:0]       w_m;
    logic [CW-1:0]       w_count;
    logic [IW-1:0]       w_waddr [COMMIT_W];
    ptr_t                w_head_post;
    ptr_t                w_tail_nxt;
    ptr_t                w_head_nxt;
    logic [KW-1:0]       w_oldest_nxt;
    logic [KW:0]         w_live_nxt;
    logic                w_take;
    logic                w_rel;

    assign w_count       = ptr_count(r_head, r_tail);
    assign count_o       = w_count;
    assign empty_o       = (w_count == '0);
    assign alloc_grant_o = (w_n <= w_count) & ~stall_i & ~ckpt_restore_i & ~flush_i & ~reset;
    assign ckpt_full_o   = (r_live == (KW+1)'(NUM_CKPT));
    assign ckpt_id_o     = r_oldest + r_live[KW-1:0];
    assign w_head_post   = alloc_grant_o ? ptr_adv(r_head, w_n) : r_head;
    assign w_tail_nxt    = ptr_adv(r_tail, w_m);
    assign w_take        = ckpt_take_i & ~stall_i & ~ckpt_full_o & (alloc_grant_o | (w_n == '0))
                         & ~ckpt_restore_i & ~flush_i;
    assign w_rel         = ckpt_release_i & (r_live != '0);

    // Requesting lanes read consecutive entries from head, in lane order.
    always_comb begin
        logic [CW-1:0] v_acc;
        ptr_t          v_rd;
        v_acc       = '0;
        alloc_reg_o = '0;
        for (int k = 0; k < DISPATCH_W; k++) begin
            v_rd = ptr_adv(r_head, v_acc);
            if (alloc_req_i[k]) begin
                alloc_reg_o[k*PHYS_LOG +: PHYS_LOG] = r_mem[v_rd[IW-1:0]];
                v_acc = v_acc + CW'(1);
            end
        end
        w_n = v_acc;
    end

    always_comb begin
        logic [CW-1:0] v_acc;
        ptr_t          v_wp;
        v_acc = '0;
        for (int j = 0; j < COMMIT_W; j++) begin
            v_wp       = ptr_adv(r_tail, v_acc);
            w_waddr[j] = v_wp[IW-1:0];
            if (free_valid_i[j]) begin
                v_acc = v_acc + CW'(1);
            end
        end
        w_m = v_acc;
    end

    // Restore keeps only the slots older than the restored one, minus a same-cycle release.
    always_comb begin
        logic [KW-1:0] v_keep;
        w_head_nxt   = r_head;
        w_oldest_nxt = r_oldest;
        w_live_nxt   = r_live;
        v_keep       = '0;
        if (flush_i) begin
            w_head_nxt   = {~w_tail_nxt[IW], w_tail_nxt[IW-1:0]};
            w_oldest_nxt = '0;
            w_live_nxt   = '0;
        end else if (ckpt_restore_i) begin
            w_head_nxt = r_slot[ckpt_restore_id_i];
            v_keep     = ckpt_restore_id_i - r_oldest;
            if (w_rel && (v_keep != '0)) begin
                v_keep = v_keep - KW'(1);
            end
            w_live_nxt   = {1'b0, v_keep};
            w_oldest_nxt = ckpt_restore_id_i - v_keep;
        end else begin
            w_head_nxt   = w_head_post;
            w_oldest_nxt = r_oldest + KW'(w_rel);
            w_live_nxt   = r_live + (KW+1)'(w_take) - (KW+1)'(w_rel);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_head   <= '0;
            r_tail   <= {1'b1, {IW{1'b0}}};
            r_oldest <= '0;
            r_live   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= PHYS_LOG'(PHYS_BASE + i);
            end
        end else begin
            for (int j = 0; j < COMMIT_W; j++) begin
                if (free_valid_i[j]) begin
                    r_mem[w_waddr[j]] <= free_reg_i[j*PHYS_LOG +: PHYS_LOG];
                end
            end
            r_head   <= w_head_nxt;
            r_tail   <= w_tail_nxt;
            r_oldest <= w_oldest_nxt;
            r_live   <= w_live_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && w_take) begin
            r_slot[ckpt_id_o] <= w_head_post;
        end
    end

endmodule
